// File: rtl/timer_counter_if.sv
// CPU data-port view of the timer: M-stage address/store data in, same-cycle
// read data, register hit and interrupt request out.
interface timer_counter_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byteen;
  logic [31:0] rdata;
  logic        hit;
  logic        irq;

  modport master (output addr, output wdata, output byteen,
                  input rdata, input hit, input irq);
  modport slave  (input addr, input wdata, input byteen,
                  output rdata, output hit, output irq);
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped programmable down-counter timer with one-shot and auto-reload
// modes; register window CTRL / PRESET / COUNT at BASE_ADDR.
module timer_counter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic            clk,
  input  logic            reset,
  timer_counter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;
  logic        irq_q, irq_d;

  logic        hit_s;
  logic        wr_ctrl_s;
  logic        wr_preset_s;
  logic [31:0] rdata_s;
  logic [31:0] ctrl_wr_s;
  logic [3:0]  ctrl_fsm_s;
  logic        irq_flag_fsm_s;
  logic        unused_addr_s;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
      else       res[8*i +: 8] = old_val[8*i +: 8];
    end
    return res;
  endfunction

  assign unused_addr_s = ^bus.addr[1:0];

  // Address decode and zero-latency read mux.
  always_comb begin
    hit_s       = (bus.addr[31:4] == BASE_ADDR[31:4]) && (bus.addr[3:2] != 2'd3);
    wr_ctrl_s   = hit_s && (bus.byteen != 4'b0000) && (bus.addr[3:2] == OFF_CTRL);
    wr_preset_s = hit_s && (bus.byteen != 4'b0000) && (bus.addr[3:2] == OFF_PRESET);
    rdata_s     = 32'h0000_0000;
    if (hit_s) begin
      case (bus.addr[3:2])
        OFF_CTRL:   rdata_s = {28'd0, ctrl_q};
        OFF_PRESET: rdata_s = preset_q;
        OFF_COUNT:  rdata_s = count_q;
        default:    rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  // Timer FSM next state, then CPU writes layered on top (they win).
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    ctrl_fsm_s     = ctrl_q;
    irq_flag_fsm_s = irq_flag_q;
    ctrl_wr_s      = merge_bytes({28'd0, ctrl_q}, bus.wdata, bus.byteen);
    case (state_q)
      ST_IDLE: begin
        if (ctrl_q[0]) state_d = ST_LOAD;
        else           state_d = ST_IDLE;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q[0]) begin
          state_d = ST_IDLE;
        end else if (count_q == 32'd0) begin
          state_d        = ST_INT;
          irq_flag_fsm_s = 1'b1;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      ST_INT: begin
        // Only mode 01 reloads; 10/11 fall back to one-shot.
        if (ctrl_q[2:1] == 2'b01) begin
          irq_flag_fsm_s = 1'b0;
          state_d        = ST_LOAD;
        end else begin
          ctrl_fsm_s[0] = 1'b0;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ctrl_d     = wr_ctrl_s ? ctrl_wr_s[3:0] : ctrl_fsm_s;
    preset_d   = wr_preset_s ? merge_bytes(preset_q, bus.wdata, bus.byteen) : preset_q;
    irq_flag_d = (wr_ctrl_s || wr_preset_s) ? 1'b0 : irq_flag_fsm_s;
    irq_d      = irq_flag_d & ctrl_d[3];
  end

  // State and register file.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.rdata = rdata_s;
  assign bus.hit   = hit_s;
  assign bus.irq   = irq_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: register/decode vector table plus
// hand-written multi-cycle sequences (auto-reload, freeze, reset mid-count).
module tb_timer_counter;

  localparam logic [31:0] B      = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL = B;
  localparam logic [31:0] A_PRE  = B + 32'd4;
  localparam logic [31:0] A_CNT  = B + 32'd8;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_hit;
    logic        exp_irq;
  } vec_t;

  logic clk;
  logic reset;
  timer_counter_if bus_if ();

  timer_counter #(.BASE_ADDR(B)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  int total;
  int bad;
  logic [31:0] obs_rdata;
  logic        obs_hit;
  logic        obs_irq;
  vec_t        vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] w,
                              input logic [3:0] be, input logic [31:0] er,
                              input logic eh, input logic ei);
    vec_t v;
    v.addr = a; v.wdata = w; v.be = be;
    v.exp_rdata = er; v.exp_hit = eh; v.exp_irq = ei;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One bus cycle: drive, sample at negedge (pre-edge state), take the edge.
  task automatic cyc(input logic [31:0] a, input logic [31:0] w, input logic [3:0] be);
    bus_if.addr   = a;
    bus_if.wdata  = w;
    bus_if.byteen = be;
    @(negedge clk);
    obs_rdata = bus_if.rdata;
    obs_hit   = bus_if.hit;
    obs_irq   = bus_if.irq;
    @(posedge clk);
    #1;
    bus_if.byteen = 4'b0000;
  endtask

  initial begin
    int i;
    logic [31:0] exp_cnt;
    logic        exp_irq;
    logic        found;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus_if.addr = A_CTRL; bus_if.wdata = 32'd0; bus_if.byteen = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", bus_if.rdata, 32'd0);
    chk("rst_hit", {31'd0, bus_if.hit}, 32'd1);
    chk("rst_irq", {31'd0, bus_if.irq}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // One-shot P=3, byte lanes, decode, then masked expiry.
    vecs.push_back(mk(A_PRE, 32'd3, 4'hF, 32'd0, 1'b1, 1'b0));
    vecs.push_back(mk(A_CTRL, 32'h9, 4'hF, 32'd0, 1'b1, 1'b0));
    vecs.push_back(mk(A_CNT, 32'd0, 4'h0, 32'd0, 1'b1, 1'b0));
    vecs.push_back(mk(A_CNT, 32'd0, 4'h0, 32'd0, 1'b1, 1'b0));
    vecs.push_back(mk(A_CNT, 32'd0, 4'h0, 32'd3, 1'b1, 1'b0));
    vecs.push_back(mk(A_CNT, 32'd0, 4'h0, 32'd2, 1'b1, 1'b0));
    vecs.push_back(mk(A_CNT, 32'd0, 4'h0, 32'd1, 1'b1, 1'b0));
    vecs.push_back(mk(A_CNT, 32'd0, 4'h0, 32'd0, 1'b1, 1'b0));
    vecs.push_back(mk(A_CTRL, 32'd0, 4'h0, 32'h9, 1'b1, 1'b1));
    vecs.push_back(mk(A_CTRL, 32'd0, 4'h0, 32'h8, 1'b1, 1'b1));
    vecs.push_back(mk(A_CNT, 32'd0, 4'h0, 32'd0, 1'b1, 1'b1));
    vecs.push_back(mk(A_PRE, 32'd7, 4'hF, 32'd3, 1'b1, 1'b1));
    vecs.push_back(mk(A_PRE, 32'd0, 4'h0, 32'd7, 1'b1, 1'b0));
    vecs.push_back(mk(A_PRE, 32'h1122_3344, 4'hF, 32'd7, 1'b1, 1'b0));
    vecs.push_back(mk(A_PRE, 32'h0000_AA00, 4'b0010, 32'h1122_3344, 1'b1, 1'b0));
    vecs.push_back(mk(A_PRE, 32'd0, 4'h0, 32'h1122_AA44, 1'b1, 1'b0));
    vecs.push_back(mk(A_CNT, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b1, 1'b0));
    vecs.push_back(mk(A_CNT, 32'd0, 4'h0, 32'd0, 1'b1, 1'b0));
    vecs.push_back(mk(B + 32'hC, 32'd0, 4'h0, 32'd0, 1'b0, 1'b0));
    vecs.push_back(mk(B + 32'h10, 32'd0, 4'h0, 32'd0, 1'b0, 1'b0));
    vecs.push_back(mk(B + 32'h3, 32'd0, 4'h0, 32'h8, 1'b1, 1'b0));
    vecs.push_back(mk(B + 32'hC, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b0, 1'b0));
    vecs.push_back(mk(B - 32'h4, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b0, 1'b0));
    vecs.push_back(mk(A_CTRL, 32'hFFFF_FFF8, 4'hF, 32'h8, 1'b1, 1'b0));
    vecs.push_back(mk(A_CTRL, 32'd0, 4'h0, 32'h8, 1'b1, 1'b0));
    vecs.push_back(mk(A_PRE, 32'd1, 4'hF, 32'h1122_AA44, 1'b1, 1'b0));
    vecs.push_back(mk(A_CTRL, 32'h1, 4'hF, 32'h8, 1'b1, 1'b0));
    vecs.push_back(mk(A_CNT, 32'd0, 4'h0, 32'd0, 1'b1, 1'b0));
    vecs.push_back(mk(A_CNT, 32'd0, 4'h0, 32'd0, 1'b1, 1'b0));
    vecs.push_back(mk(A_CNT, 32'd0, 4'h0, 32'd1, 1'b1, 1'b0));
    vecs.push_back(mk(A_CNT, 32'd0, 4'h0, 32'd0, 1'b1, 1'b0));
    vecs.push_back(mk(A_CTRL, 32'd0, 4'h0, 32'h1, 1'b1, 1'b0));
    vecs.push_back(mk(A_CTRL, 32'd0, 4'h0, 32'h0, 1'b1, 1'b0));
    vecs.push_back(mk(A_CTRL, 32'h8, 4'hF, 32'h0, 1'b1, 1'b0));
    vecs.push_back(mk(A_CTRL, 32'd0, 4'h0, 32'h8, 1'b1, 1'b0));
    vecs.push_back(mk(A_CTRL, 32'd0, 4'h0, 32'h8, 1'b1, 1'b0));

    for (int v = 0; v < vecs.size(); v++) begin
      cyc(vecs[v].addr, vecs[v].wdata, vecs[v].be);
      chk($sformatf("vec%0d_rdata", v), obs_rdata, vecs[v].exp_rdata);
      chk($sformatf("vec%0d_hit", v), {31'd0, obs_hit}, {31'd0, vecs[v].exp_hit});
      chk($sformatf("vec%0d_irq", v), {31'd0, obs_irq}, {31'd0, vecs[v].exp_irq});
    end

    // Auto-reload P=2: 5-cycle period, single-cycle irq.
    cyc(A_PRE, 32'd2, 4'hF);
    cyc(A_CTRL, 32'hB, 4'hF);
    for (i = 0; i < 16; i++) begin
      cyc(A_CNT, 32'd0, 4'h0);
      if (i < 2) exp_cnt = 32'd0;
      else begin
        case ((i - 2) % 5)
          0:       exp_cnt = 32'd2;
          1:       exp_cnt = 32'd1;
          default: exp_cnt = 32'd0;
        endcase
      end
      exp_irq = (i >= 5) && (((i - 5) % 5) == 0);
      chk($sformatf("ar_cnt%0d", i), obs_rdata, exp_cnt);
      chk($sformatf("ar_irq%0d", i), {31'd0, obs_irq}, {31'd0, exp_irq});
    end
    cyc(A_CTRL, 32'h0, 4'hF);
    repeat (4) cyc(A_CNT, 32'd0, 4'h0);
    chk("ar_off_irq", {31'd0, obs_irq}, 32'd0);

    // Disable mid-count: the coinciding decrement lands, then COUNT freezes.
    cyc(A_PRE, 32'd6, 4'hF);
    cyc(A_CTRL, 32'h1, 4'hF);
    for (i = 0; i < 4; i++) begin
      cyc(A_CNT, 32'd0, 4'h0);
      if (i >= 2) chk($sformatf("fr_cnt%0d", i), obs_rdata, 32'd8 - 32'(i));
    end
    cyc(A_CTRL, 32'h0, 4'hF);
    chk("fr_ctrl", obs_rdata, 32'h1);
    for (i = 5; i < 9; i++) begin
      cyc(A_CNT, 32'd0, 4'h0);
      chk($sformatf("fr_hold%0d", i), obs_rdata, 32'd3);
    end
    cyc(A_CNT, 32'hFFFF_FFFF, 4'hF);
    cyc(A_CNT, 32'd0, 4'h0);
    chk("cnt_ro", obs_rdata, 32'd3);
    cyc(A_CTRL, 32'h1, 4'hF);
    cyc(A_CNT, 32'd0, 4'h0);
    chk("re_cnt0", obs_rdata, 32'd3);
    cyc(A_CNT, 32'd0, 4'h0);
    cyc(A_CNT, 32'd0, 4'h0);
    chk("re_reload", obs_rdata, 32'd6);

    // Asynchronous reset while COUNT=5 and EN=1.
    cyc(A_CTRL, 32'h0, 4'hF);
    cyc(A_PRE, 32'd9, 4'hF);
    cyc(A_CTRL, 32'h9, 4'hF);
    found = 1'b0;
    for (i = 0; i < 20; i++) begin
      if (!found) begin
        cyc(A_CNT, 32'd0, 4'h0);
        if (obs_rdata == 32'd5) found = 1'b1;
      end
    end
    chk("rm_reach5", {31'd0, found}, 32'd1);
    #2;
    reset = 1'b0;
    bus_if.addr = A_CNT;
    #1;
    chk("rm_cnt", bus_if.rdata, 32'd0);
    chk("rm_irq", {31'd0, bus_if.irq}, 32'd0);
    bus_if.addr = A_CTRL;
    #1;
    chk("rm_ctrl", bus_if.rdata, 32'd0);
    bus_if.addr = A_PRE;
    #1;
    chk("rm_pre", bus_if.rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (i = 0; i < 6; i++) begin
      cyc(A_CNT, 32'd0, 4'h0);
      chk($sformatf("rm_idle%0d", i), obs_rdata, 32'd0);
      chk($sformatf("rm_irq%0d", i), {31'd0, obs_irq}, 32'd0);
    end
    cyc(A_CTRL, 32'd0, 4'h0);
    chk("rm_ctrl_after", obs_rdata, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
